// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// One outstanding request; mem_ack completes it and qualifies mem_rdata.
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory transaction per accepted instruction,
// with alignment/legality checks, ack timeout and register write-back.
module load_store_unit #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      is_load,
   input  logic                      is_store,
   input  logic [2:0]                funct3,
   input  logic [31:0]               rs1_data,
   input  logic [31:0]               rs2_data,
   input  logic [31:0]               imm,
   input  logic [4:0]                rd_in,
   load_store_unit_if.master         mem,
   output logic                      reg_write,
   output logic [4:0]                rd,
   output logic [31:0]               rd_data,
   output logic                      fault,
   output logic [31:0]               fault_addr
);
   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

   localparam logic [15:0] TMO_LIMIT = 16'(ACK_TIMEOUT);

   state_t      state_reg, state_next;
   logic        mem_req_reg, mem_req_next;
   logic        mem_we_reg, mem_we_next;
   logic [31:0] mem_addr_reg, mem_addr_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
   logic        reg_write_reg, reg_write_next;
   logic [4:0]  rd_reg, rd_next;
   logic [31:0] rd_data_reg, rd_data_next;
   logic        fault_reg, fault_next;
   logic [31:0] fault_addr_reg, fault_addr_next;
   logic [15:0] tmo_cnt_reg, tmo_cnt_next;
   logic [31:0] ea_lat_reg, ea_lat_next;
   logic [2:0]  f3_lat_reg, f3_lat_next;
   logic        ld_lat_reg, ld_lat_next;
   logic [4:0]  rd_lat_reg, rd_lat_next;

   logic [31:0] ea;
   logic        accept;
   logic        illegal;
   logic        misaligned;
   logic [3:0]  byte_strb;
   logic [31:0] shifted;
   logic [31:0] load_val;
   logic        tmo_hit;

   assign ea     = rs1_data + imm;
   assign accept = in_valid && (is_load || is_store);

   assign illegal = (is_load && is_store)
                 || (is_load  && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
                 || (is_store && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010));

   // funct3[1:0] encodes width for both loads and stores (00 byte, 01 half, 10 word)
   assign misaligned = ((funct3[1:0] == 2'b01) && ea[0])
                    || ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_strb
         assign byte_strb[gi] = (ea[1:0] == 2'(gi));
      end
   endgenerate

   assign shifted = mem.mem_rdata >> {ea_lat_reg[1:0], 3'b000};

   always_comb begin
      load_val = mem.mem_rdata;
      case (f3_lat_reg)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = mem.mem_rdata;
      endcase
   end

   assign tmo_hit = (TMO_LIMIT != 16'd0) && (tmo_cnt_reg == TMO_LIMIT - 16'd1);

   always_comb begin
      state_next      = state_reg;
      mem_req_next    = mem_req_reg;
      mem_we_next     = mem_we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      mem_wstrb_next  = mem_wstrb_reg;
      reg_write_next  = 1'b0;
      rd_next         = rd_reg;
      rd_data_next    = rd_data_reg;
      fault_next      = 1'b0;
      fault_addr_next = fault_addr_reg;
      tmo_cnt_next    = tmo_cnt_reg;
      ea_lat_next     = ea_lat_reg;
      f3_lat_next     = f3_lat_reg;
      ld_lat_next     = ld_lat_reg;
      rd_lat_next     = rd_lat_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (illegal || misaligned) begin
                  fault_next      = 1'b1;
                  fault_addr_next = ea;
               end else begin
                  state_next     = REQ;
                  mem_req_next   = 1'b1;
                  mem_addr_next  = {ea[31:2], 2'b00};
                  mem_we_next    = is_store;
                  mem_wdata_next = rs2_data;
                  mem_wstrb_next = 4'b0000;
                  if (is_store) begin
                     case (funct3[1:0])
                        2'b00: begin
                           mem_wstrb_next = byte_strb;
                           mem_wdata_next = {4{rs2_data[7:0]}};
                        end
                        2'b01: begin
                           mem_wstrb_next = ea[1] ? 4'b1100 : 4'b0011;
                           mem_wdata_next = {2{rs2_data[15:0]}};
                        end
                        default: mem_wstrb_next = 4'b1111;
                     endcase
                  end
                  tmo_cnt_next = 16'd0;
                  ea_lat_next  = ea;
                  f3_lat_next  = funct3;
                  ld_lat_next  = is_load;
                  rd_lat_next  = rd_in;
               end
            end
         end
         REQ: begin
            // An ack in the limit cycle takes priority over the timeout
            if (mem.mem_ack) begin
               mem_req_next   = 1'b0;
               mem_we_next    = 1'b0;
               mem_wstrb_next = 4'b0000;
               tmo_cnt_next   = 16'd0;
               if (ld_lat_reg) begin
                  state_next     = WB;
                  rd_data_next   = load_val;
                  rd_next        = rd_lat_reg;
                  reg_write_next = (rd_lat_reg != 5'd0);
               end else begin
                  state_next = IDLE;
               end
            end else if (tmo_hit) begin
               mem_req_next    = 1'b0;
               mem_we_next     = 1'b0;
               mem_wstrb_next  = 4'b0000;
               tmo_cnt_next    = 16'd0;
               fault_next      = 1'b1;
               fault_addr_next = ea_lat_reg;
               state_next      = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 16'd1;
            end
         end
         WB: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= 32'd0;
         mem_wdata_reg  <= 32'd0;
         mem_wstrb_reg  <= 4'd0;
         reg_write_reg  <= 1'b0;
         rd_reg         <= 5'd0;
         rd_data_reg    <= 32'd0;
         fault_reg      <= 1'b0;
         fault_addr_reg <= 32'd0;
         tmo_cnt_reg    <= 16'd0;
         ea_lat_reg     <= 32'd0;
         f3_lat_reg     <= 3'd0;
         ld_lat_reg     <= 1'b0;
         rd_lat_reg     <= 5'd0;
      end else begin
         state_reg      <= state_next;
         mem_req_reg    <= mem_req_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         mem_wstrb_reg  <= mem_wstrb_next;
         reg_write_reg  <= reg_write_next;
         rd_reg         <= rd_next;
         rd_data_reg    <= rd_data_next;
         fault_reg      <= fault_next;
         fault_addr_reg <= fault_addr_next;
         tmo_cnt_reg    <= tmo_cnt_next;
         ea_lat_reg     <= ea_lat_next;
         f3_lat_reg     <= f3_lat_next;
         ld_lat_reg     <= ld_lat_next;
         rd_lat_reg     <= rd_lat_next;
      end
   end

   assign in_ready      = (state_reg == IDLE);
   assign mem.mem_req   = mem_req_reg;
   assign mem.mem_we    = mem_we_reg;
   assign mem.mem_addr  = mem_addr_reg;
   assign mem.mem_wdata = mem_wdata_reg;
   assign mem.mem_wstrb = mem_wstrb_reg;
   assign reg_write     = reg_write_reg;
   assign rd            = rd_reg;
   assign rd_data       = rd_data_reg;
   assign fault         = fault_reg;
   assign fault_addr    = fault_addr_reg;
endmodule
